// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// default HLT opcode, PC increment and reset PC, plus small helpers.
package if_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,  // request outstanding, waiting for a response
    ST_HOLD = 2'b01,  // response buffered while the hazard unit stalls
    ST_DROP = 2'b10,  // stale response still outstanding after a redirect
    ST_HALT = 2'b11   // HLT delivered, fetch frozen until a redirect
  } fetch_state_t;

  localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] PC_INC         = 16'h0002;
  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [15:0] PC_ALIGN_MASK  = 16'hFFFE;

  // True when the instruction word carries the HLT opcode
  function automatic logic is_hlt(input logic [15:0] instr, input logic [3:0] hlt_op);
    return (instr[15:12] == hlt_op);
  endfunction

  // Sequential next PC, wrapping modulo 2^16
  function automatic logic [15:0] pc_plus_inc(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage. Loads either PC+2 or a
// halfword-aligned branch target when enabled; bit 0 is always kept clear.
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_sel_branch,
  input  logic [15:0] i_target,
  output logic [15:0] o_pc,
  output logic [15:0] o_pc_inc
);

  logic [15:0] r_pc;
  logic [15:0] w_pc_inc;
  logic [15:0] w_target_aligned;

  assign w_pc_inc         = pc_plus_inc(r_pc);
  assign w_target_aligned = i_target & PC_ALIGN_MASK;
  assign o_pc             = r_pc;
  assign o_pc_inc         = w_pc_inc;

  // PC update: reset, redirect to target, sequential advance, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC & PC_ALIGN_MASK;
    end else if (i_en) begin
      r_pc <= i_sel_branch ? w_target_aligned : w_pc_inc;
    end else begin
      r_pc <= r_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, drives a
// variable-latency request/valid handshake, honours stalls and redirects,
// and freezes after delivering HLT.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallIn,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic [15:0] IMemAddr,
  output logic        IMemReq,
  input  logic [15:0] IMemData,
  input  logic        IMemValid,
  output logic [15:0] InstructionOut,
  output logic [15:0] PCOut,
  output logic        HltOut,
  output logic        NoopOut
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [15:0]  r_buf;

  logic [15:0] w_pc;
  logic [15:0] w_pc_inc;
  logic        w_pc_en;
  logic        w_pc_sel_branch;
  logic        w_buf_load;
  logic        w_deliver;
  logic        w_req;
  logic        w_noop;
  logic        w_hlt;
  logic [15:0] w_instr;
  logic [15:0] w_pcout;
  logic        w_mem_is_hlt;
  logic        w_buf_is_hlt;

  assign w_mem_is_hlt = is_hlt(IMemData, HLT_OPCODE);
  assign w_buf_is_hlt = is_hlt(r_buf, HLT_OPCODE);

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_pc_en),
    .i_sel_branch (w_pc_sel_branch),
    .i_target     (BranchTarget),
    .o_pc         (w_pc),
    .o_pc_inc     (w_pc_inc)
  );

  // Next-state, PC control and IF/ID outputs; a redirect always wins and
  // suppresses whatever would have been presented that cycle
  always_comb begin
    w_state_next    = r_state;
    w_pc_en         = 1'b0;
    w_pc_sel_branch = 1'b0;
    w_buf_load      = 1'b0;
    w_deliver       = 1'b0;
    w_req           = 1'b0;
    w_noop          = 1'b1;
    w_hlt           = 1'b0;
    w_instr         = 16'h0000;
    w_pcout         = 16'h0000;
    if (rst) begin
      w_state_next = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT: begin
          w_req = 1'b1;
          if (BranchTaken) begin
            w_pc_en         = 1'b1;
            w_pc_sel_branch = 1'b1;
            // Response arriving now is simply dropped; otherwise it is still in flight
            w_state_next    = IMemValid ? ST_WAIT : ST_DROP;
          end else if (IMemValid) begin
            w_instr = IMemData;
            w_pcout = w_pc_inc;
            w_noop  = 1'b0;
            w_hlt   = w_mem_is_hlt;
            if (StallIn) begin
              w_buf_load   = 1'b1;
              w_state_next = ST_HOLD;
            end else begin
              w_deliver = 1'b1;
              if (w_mem_is_hlt) begin
                w_state_next = ST_HALT;
              end else begin
                w_pc_en = 1'b1;
              end
            end
          end else begin
            w_noop = 1'b1;
          end
        end
        ST_HOLD: begin
          if (BranchTaken) begin
            w_pc_en         = 1'b1;
            w_pc_sel_branch = 1'b1;
            w_state_next    = ST_WAIT;
          end else begin
            w_instr = r_buf;
            w_pcout = w_pc_inc;
            w_noop  = 1'b0;
            w_hlt   = w_buf_is_hlt;
            if (!StallIn) begin
              w_deliver = 1'b1;
              if (w_buf_is_hlt) begin
                w_state_next = ST_HALT;
              end else begin
                w_pc_en      = 1'b1;
                w_state_next = ST_WAIT;
              end
            end else begin
              w_state_next = ST_HOLD;
            end
          end
        end
        ST_DROP: begin
          w_req = 1'b1;
          if (BranchTaken) begin
            w_pc_en         = 1'b1;
            w_pc_sel_branch = 1'b1;
            // If the stale response lands now, the new target can be requested next
            w_state_next    = IMemValid ? ST_WAIT : ST_DROP;
          end else if (IMemValid) begin
            w_state_next = ST_WAIT;
          end else begin
            w_state_next = ST_DROP;
          end
        end
        ST_HALT: begin
          if (BranchTaken) begin
            w_pc_en         = 1'b1;
            w_pc_sel_branch = 1'b1;
            w_state_next    = ST_WAIT;
          end else begin
            w_state_next = ST_HALT;
          end
        end
        default: begin
          w_state_next = ST_WAIT;
        end
      endcase
    end
  end

  assign IMemReq        = w_req;
  assign IMemAddr       = w_pc & PC_ALIGN_MASK;
  assign InstructionOut = w_instr;
  assign PCOut          = w_pcout;
  assign HltOut         = w_hlt;
  assign NoopOut        = w_noop;

  // FSM state and stall buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT;
      r_buf   <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_buf   <= w_buf_load ? IMemData : r_buf;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating counters of delivered instructions and bubble cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= 32'h0000_0000;
      r_bubble_cnt <= 32'h0000_0000;
    end else begin
      if (w_deliver && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'h0000_0001;
      end else begin
        r_fetch_cnt <= r_fetch_cnt;
      end
      if (w_noop && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'h0000_0001;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign FetchCount  = r_fetch_cnt;
  assign BubbleCount = r_bubble_cnt;
`endif

endmodule
